// File: rtl/alu_cmd_sequencer.sv
// Register-addressed command front-end for the combinational 32-bit ALU.
// Each command takes three cycles: accept (IDLE), EXEC, then write-back (WB).
module alu_cmd_sequencer #(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 8,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [AW-1:0]     cmd_rd,
  input  logic [AW-1:0]     cmd_rs1,
  input  logic [AW-1:0]     cmd_rs2,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done_valid,
  output logic [AW-1:0]     done_rd,
  output logic [DATA_W-1:0] done_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];
  logic              accept_s;

  assign accept_s = cmd_valid && (state_q == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_s) state_d = S_EXEC; else state_d = S_IDLE;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = 1'b0;
    done_valid = 1'b0;
    case (state_q)
      S_IDLE:  cmd_ready  = 1'b1;
      S_EXEC:  cmd_ready  = 1'b0;
      S_WB:    done_valid = 1'b1;
      default: cmd_ready  = 1'b0;
    endcase
  end

  // Operands are read from the pre-edge register file, so a host write on the
  // accept edge is not seen; the WB write is applied last so it wins a collision.
  always_comb begin
    op_d  = op_q;
    rd_d  = rd_q;
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    rf_d  = rf_q;
    if (accept_s) begin
      op_d = cmd_op;
      rd_d = cmd_rd;
      a_d  = rf_q[cmd_rs1];
      b_d  = rf_q[cmd_rs2];
    end else begin
      op_d = op_q;
    end
    if (state_q == S_EXEC) begin
      res_d = alu_result;
    end else begin
      res_d = res_q;
    end
    if (wr_en) begin
      rf_d[wr_addr] = wr_data;
    end else begin
      rf_d[wr_addr] = rf_q[wr_addr];
    end
    if (state_q == S_WB) begin
      rf_d[rd_q] = res_q;
    end else begin
      rf_d[rd_q] = rf_d[rd_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= 3'd0;
      rd_q  <= {AW{1'b0}};
      a_q   <= {DATA_W{1'b0}};
      b_q   <= {DATA_W{1'b0}};
      res_q <= {DATA_W{1'b0}};
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      op_q  <= op_d;
      rd_q  <= rd_d;
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // Latched operands drive the ALU from EXEC onward and simply hold afterwards.
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign done_rd    = rd_q;
  assign done_data  = res_q;
  assign rd_data    = rf_q[rd_addr];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: directed test-plan steps plus randomized commands,
// checked against an array-based register-file model and an arithmetic ALU.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_opcode;
  logic        done_valid;
  logic [2:0]  done_rd;
  logic [31:0] done_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] rf_m [8];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a + 32'd1;
      3'd3:    return a - 32'd1;
      3'd4:    return a;
      3'd5:    return ~a;
      3'd6:    return a | b;
      3'd7:    return a & b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_a, alu_b);

  alu_cmd_sequencer #(.DATA_W(32), .NREGS(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .done_valid(done_valid), .done_rd(done_rd), .done_data(done_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic host_write(input logic [2:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(posedge clk);
    rf_m[addr] = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2,
                        input bit wa_en, input logic [2:0] wa_addr, input logic [31:0] wa_data,
                        input bit wb_en, input logic [2:0] wb_addr, input logic [31:0] wb_data,
                        output logic [31:0] got);
    logic [31:0] ea, eb, exp;
    ea = rf_m[rs1];
    eb = rf_m[rs2];
    exp = alu_f(op, ea, eb);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    wr_en = wa_en; wr_addr = wa_addr; wr_data = wa_data;
    rd_addr = rs1;
    #1;
    check("ready_idle", {31'd0, cmd_ready}, 32'd1);
    check("rd_data_pre", rd_data, ea);
    @(posedge clk);
    if (wa_en) rf_m[wa_addr] = wa_data;
    @(negedge clk);
    cmd_valid = 1'b0; wr_en = 1'b0;
    cmd_op = 3'($urandom); cmd_rd = 3'($urandom);
    cmd_rs1 = 3'($urandom); cmd_rs2 = 3'($urandom);
    check("ready_exec", {31'd0, cmd_ready}, 32'd0);
    check("done_exec", {31'd0, done_valid}, 32'd0);
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    check("alu_opcode", {29'd0, alu_opcode}, {29'd0, op});
    @(posedge clk);
    @(negedge clk);
    check("done_valid_wb", {31'd0, done_valid}, 32'd1);
    check("ready_wb", {31'd0, cmd_ready}, 32'd0);
    check("done_rd", {29'd0, done_rd}, {29'd0, rd});
    check("done_data", done_data, exp);
    got = done_data;
    wr_en = wb_en; wr_addr = wb_addr; wr_data = wb_data;
    @(posedge clk);
    if (wb_en) rf_m[wb_addr] = wb_data;
    rf_m[rd] = exp;
    @(negedge clk);
    wr_en = 1'b0;
    rd_addr = rd;
    #1;
    check("done_after", {31'd0, done_valid}, 32'd0);
    check("ready_after", {31'd0, cmd_ready}, 32'd1);
    check("alu_a_hold", alu_a, ea);
    check("rd_data_rd", rd_data, rf_m[rd]);
    if (wb_en) begin
      rd_addr = wb_addr;
      #1;
      check("rd_data_wbhost", rd_data, rf_m[wb_addr]);
    end
  endtask

  task automatic check_all_rf(input string tag);
    for (int r = 0; r < 8; r++) begin
      rd_addr = 3'(r);
      #1;
      check(tag, rd_data, rf_m[r]);
    end
  endtask

  initial begin
    logic [31:0] got, v;
    logic [31:0] dq[$];
    logic [31:0] sweep_exp [8];
    sweep_exp[1] = 32'h00000002; sweep_exp[2] = 32'h00000006; sweep_exp[3] = 32'h00000004;
    sweep_exp[4] = 32'h00000005; sweep_exp[5] = 32'hFFFFFFFA; sweep_exp[6] = 32'h00000007;
    sweep_exp[7] = 32'h00000001;
    for (int r = 0; r < 8; r++) rf_m[r] = 32'd0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_rd = 3'd0; cmd_rs1 = 3'd0;
    cmd_rs2 = 3'd0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 32'd0; rd_addr = 3'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_done_valid", {31'd0, done_valid}, 32'd0);
    check("rst_done_rd", {29'd0, done_rd}, 32'd0);
    check("rst_done_data", done_data, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_op", {29'd0, alu_opcode}, 32'd0);
    rst = 1'b0;
    check_all_rf("rst_rf");

    // Basic add, then opcode sweep from the same preload.
    host_write(3'd1, 32'd5);
    host_write(3'd2, 32'd3);
    do_cmd(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, got);
    check("plan_add", got, 32'h00000008);
    for (int op = 1; op < 8; op++) begin
      do_cmd(3'(op), 3'd4, 3'd1, 3'd2, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, got);
      check("plan_sweep", got, sweep_exp[op]);
    end

    // Wrap-around both ways.
    host_write(3'd5, 32'd0);
    do_cmd(3'd3, 3'd5, 3'd5, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, got);
    check("wrap_dec", got, 32'hFFFFFFFF);
    host_write(3'd6, 32'hFFFFFFFF);
    do_cmd(3'd2, 3'd6, 3'd6, 3'd6, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, got);
    check("wrap_inc", got, 32'h00000000);

    // cmd_valid held for 9 cycles: accepts only every third edge.
    host_write(3'd1, 32'd5);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_rd = 3'd1; cmd_rs1 = 3'd1; cmd_rs2 = 3'd0;
    for (int c = 0; c < 9; c++) begin
      #1;
      check("hold_ready", {31'd0, cmd_ready}, {31'd0, (c % 3) == 0});
      @(posedge clk);
      @(negedge clk);
      check("hold_done", {31'd0, done_valid}, {31'd0, (c % 3) == 1});
      if (done_valid) dq.push_back(done_data);
    end
    cmd_valid = 1'b0;
    check("hold_count", 32'(dq.size()), 32'd3);
    v = rf_m[1];
    for (int k = 0; k < 3; k++) begin
      v = v + 32'd1;
      if (k < dq.size()) check("hold_data", dq[k], v);
    end
    rf_m[1] = v;
    check_all_rf("hold_rf");

    // Collisions: host write on WB edge to rd, host write on accept edge to rs1.
    do_cmd(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 32'd0, 1'b1, 3'd3, 32'hDEADBEEF, got);
    do_cmd(3'd0, 3'd4, 3'd1, 3'd2, 1'b1, 3'd1, 32'h00000100, 1'b0, 3'd0, 32'd0, got);
    check("old_operand", got, 32'h0000000B);
    do_cmd(3'd0, 3'd1, 3'd1, 3'd1, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, got);
    check("same_regs", got, 32'h00000200);

    // Reset while in EXEC drops the command.
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rd = 3'd7; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_exec_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_exec_done", {31'd0, done_valid}, 32'd0);
    check("rst_exec_alu_a", alu_a, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 8; r++) rf_m[r] = 32'd0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_no_done", {31'd0, done_valid}, 32'd0);
    end
    check_all_rf("rst_exec_rf");
    host_write(3'd1, 32'd5);
    do_cmd(3'd0, 3'd3, 3'd1, 3'd1, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, got);
    check("post_rst_cmd", got, 32'h0000000A);

    // Randomized commands with random host-write collisions.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) host_write(3'($urandom), $urandom);
      do_cmd(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
             $urandom_range(0, 2) == 0, 3'($urandom), $urandom,
             $urandom_range(0, 2) == 0, 3'($urandom), $urandom, got);
    end
    check_all_rf("final_rf");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
